// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the EX-stage control-transfer logic:
// branch funct3 codes, transfer kind encoding and the branch FSM states.
package riscv_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'd0,
    KIND_JAL    = 2'd1,
    KIND_JALR   = 2'd2,
    KIND_RSVD   = 2'd3
  } br_kind_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude/equality comparator shared by all branch conditions.
module comparator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_eq,
  output logic             o_lt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a <  i_b);

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: evaluates conditions on one shared comparator,
// issues a registered PC redirect, then holds flush to squash IF/ID.
module branch_ctrl
  import riscv_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [1:0]       br_kind,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic             redirect,
  output logic [WIDTH-1:0] target,
  output logic             flush,
  output logic             misalign,
  output logic             busy,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0]       FLUSH_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;
  localparam logic [WIDTH-1:0] MSB_MASK   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] JALR_MASK  = {{(WIDTH-1){1'b1}}, 1'b0};

  br_state_e        r_state;
  br_state_e        w_state_nxt;
  br_kind_e         w_kind;
  logic [1:0]       r_flush_cnt;
  logic [WIDTH-1:0] r_target;
  logic             r_misalign;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_signed;
  logic [WIDTH-1:0] w_cmp_a;
  logic [WIDTH-1:0] w_cmp_b;
  logic             w_eq;
  logic             w_lt;
  logic             w_cond;
  logic             w_taken;
  logic [WIDTH-1:0] w_jalr_sum;
  logic [WIDTH-1:0] w_target;
  logic             w_accept;
  logic             w_take;

  assign w_kind = br_kind_e'(br_kind);

  // Flipping both MSBs maps two's-complement order onto unsigned order,
  // so BLT/BGE reuse the unsigned comparator.
  assign w_signed = ~funct3[1];
  assign w_cmp_a  = w_signed ? (rs1_data ^ MSB_MASK) : rs1_data;
  assign w_cmp_b  = w_signed ? (rs2_data ^ MSB_MASK) : rs2_data;

  comparator #(.WIDTH(WIDTH)) u_cmp (
    .i_a  (w_cmp_a),
    .i_b  (w_cmp_b),
    .o_eq (w_eq),
    .o_lt (w_lt)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_cond = 1'b0;
    case (funct3)
      BR_BEQ:           w_cond = w_eq;
      BR_BNE:           w_cond = ~w_eq;
      BR_BLT, BR_BLTU:  w_cond = w_lt;
      BR_BGE, BR_BGEU:  w_cond = ~w_lt;
      default:          w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_kind)
      KIND_BRANCH: w_taken = w_cond;
      KIND_JAL:    w_taken = 1'b1;
      KIND_JALR:   w_taken = 1'b1;
      default:     w_taken = 1'b0;
    endcase
  end

  assign w_jalr_sum = rs1_data + imm;
  assign w_target   = (w_kind == KIND_JALR) ? (w_jalr_sum & JALR_MASK) : (pc + imm);

  // Instructions seen outside IDLE are wrong-path and never accepted.
  assign w_accept = br_valid & ~stall & (r_state == IDLE);
  assign w_take   = w_accept & w_taken;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_take && !w_target[1]) w_state_nxt = REDIRECT;
      REDIRECT: w_state_nxt = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
      FLUSH:    if (r_flush_cnt == 2'd0) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_flush_cnt <= 2'd0;
      r_target    <= '0;
      r_misalign  <= 1'b0;
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (!stall) begin
      r_state <= w_state_nxt;
      if (r_state == REDIRECT)
        r_flush_cnt <= FLUSH_INIT;
      else if (r_state == FLUSH && r_flush_cnt != 2'd0)
        r_flush_cnt <= r_flush_cnt - 2'd1;
      if (w_take)
        r_target <= w_target;
      r_misalign <= w_take & w_target[1];
      if (w_accept && r_br_cnt != {CNT_W{1'b1}})
        r_br_cnt <= r_br_cnt + 1'b1;
      if (w_take && r_taken_cnt != {CNT_W{1'b1}})
        r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

  assign redirect  = (r_state == REDIRECT);
  assign flush     = (r_state != IDLE);
  assign busy      = (r_state != IDLE);
  assign target    = r_target;
  assign misalign  = r_misalign;
  assign br_cnt    = r_br_cnt;
  assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: two instances (default, and FLUSH_CYCLES=3/CNT_W=4)
// compared every cycle against a countdown model, plus directed literal checks.
module tb_branch_ctrl;
  import riscv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, stall, br_valid;
  logic [1:0]   br_kind;
  logic [2:0]   funct3;
  logic [W-1:0] rs1_data, rs2_data, pc, imm;

  logic         a_redirect, a_flush, a_misalign, a_busy;
  logic [W-1:0] a_target;
  logic [15:0]  a_br_cnt, a_taken_cnt;
  logic         b_redirect, b_flush, b_misalign, b_busy;
  logic [W-1:0] b_target;
  logic [3:0]   b_br_cnt, b_taken_cnt;

  branch_ctrl #(.WIDTH(W), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_kind(br_kind), .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .imm(imm), .redirect(a_redirect), .target(a_target), .flush(a_flush),
    .misalign(a_misalign), .busy(a_busy), .br_cnt(a_br_cnt), .taken_cnt(a_taken_cnt)
  );

  branch_ctrl #(.WIDTH(W), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_kind(br_kind), .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .imm(imm), .redirect(b_redirect), .target(b_target), .flush(b_flush),
    .misalign(b_misalign), .busy(b_busy), .br_cnt(b_br_cnt), .taken_cnt(b_taken_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: `left` = cycles of flush still to show.
  typedef struct {
    int          left;
    bit          redirect;
    bit          misalign;
    logic [31:0] target;
    int          br_cnt;
    int          taken_cnt;
  } mdl_t;

  mdl_t ma, mb;

  function automatic bit ref_taken(input logic [1:0] k, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
    if (k == 2'd1 || k == 2'd2) return 1'b1;
    if (k == 2'd3) return 1'b0;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [1:0] k, input logic [31:0] a,
                                             input logic [31:0] p, input logic [31:0] i);
    logic [31:0] s;
    if (k == 2'd2) begin
      s = a + i;
      s[0] = 1'b0;
      return s;
    end
    return p + i;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int fc, input int cmax);
    mdl_t n;
    logic [31:0] t;
    n = m;
    if (reset) begin
      n.left = 0; n.redirect = 0; n.misalign = 0; n.target = '0;
      n.br_cnt = 0; n.taken_cnt = 0;
    end else if (!stall) begin
      n.redirect = 0;
      n.misalign = 0;
      if (m.left > 0) begin
        n.left = m.left - 1;
      end else if (br_valid) begin
        if (n.br_cnt < cmax) n.br_cnt++;
        if (ref_taken(br_kind, funct3, rs1_data, rs2_data)) begin
          if (n.taken_cnt < cmax) n.taken_cnt++;
          t = ref_target(br_kind, rs1_data, pc, imm);
          n.target = t;
          if (t[1]) n.misalign = 1;
          else begin
            n.left = fc;
            n.redirect = 1;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, 2, 65535);
    mb <= step(mb, 3, 15);
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("a.redirect",  a_redirect,  ma.redirect);
      check("a.flush",     a_flush,     ma.left > 0);
      check("a.busy",      a_busy,      ma.left > 0);
      check("a.misalign",  a_misalign,  ma.misalign);
      check("a.target",    a_target,    ma.target);
      check("a.br_cnt",    a_br_cnt,    ma.br_cnt);
      check("a.taken_cnt", a_taken_cnt, ma.taken_cnt);
      check("b.redirect",  b_redirect,  mb.redirect);
      check("b.flush",     b_flush,     mb.left > 0);
      check("b.busy",      b_busy,      mb.left > 0);
      check("b.misalign",  b_misalign,  mb.misalign);
      check("b.target",    b_target,    mb.target);
      check("b.br_cnt",    b_br_cnt,    mb.br_cnt);
      check("b.taken_cnt", b_taken_cnt, mb.taken_cnt);
    end
  end

  task automatic set_br(input logic [1:0] k, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] i);
    br_kind = k; funct3 = f; rs1_data = a; rs2_data = b; pc = p; imm = i;
  endtask

  // Called at a negedge; returns at the negedge of cycle N+1.
  task automatic issue(input logic [1:0] k, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] i);
    set_br(k, f, a, b, p, i);
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_valid = 1'b0;
    set_br(2'd0, 3'd0, '0, '0, '0, '0);
    idle(2);
    check_en = 1'b1;
    check("rst.redirect", a_redirect, 1'b0);
    check("rst.flush",    a_flush,    1'b0);
    check("rst.busy",     a_busy,     1'b0);
    check("rst.target",   a_target,   32'h0);
    check("rst.br_cnt",   a_br_cnt,   16'd0);
    reset = 1'b0;

    // BEQ taken: redirect/flush timing
    issue(2'd0, BR_BEQ, 32'h5, 32'h5, 32'h100, 32'h20);
    check("beq.n1.redirect", a_redirect, 1'b1);
    check("beq.n1.target",   a_target,   32'h120);
    check("beq.n1.flush",    a_flush,    1'b1);
    idle(1);
    check("beq.n2.flush",    a_flush,    1'b1);
    check("beq.n2.redirect", a_redirect, 1'b0);
    idle(1);
    check("beq.n3.flush",    a_flush,    1'b0);
    check("beq.br_cnt",      a_br_cnt,   16'd1);
    check("beq.taken_cnt",   a_taken_cnt, 16'd1);
    idle(2);

    // signed vs unsigned with the same operands
    issue(2'd0, BR_BLT, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40);
    check("blt.redirect", a_redirect, 1'b1);
    check("blt.target",   a_target,   32'h240);
    idle(3);
    issue(2'd0, BR_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40);
    check("bltu.redirect",  a_redirect,  1'b0);
    check("bltu.flush",     a_flush,     1'b0);
    check("bltu.br_cnt",    a_br_cnt,    16'd3);
    check("bltu.taken_cnt", a_taken_cnt, 16'd2);
    idle(1);

    // JALR misaligned, then aligned
    issue(2'd2, 3'd0, 32'h203, 32'h0, 32'h400, 32'h0);
    check("jalr.mis.misalign", a_misalign, 1'b1);
    check("jalr.mis.redirect", a_redirect, 1'b0);
    check("jalr.mis.target",   a_target,   32'h202);
    check("jalr.mis.taken",    a_taken_cnt, 16'd3);
    idle(1);
    check("jalr.mis.pulse_end", a_misalign, 1'b0);
    issue(2'd2, 3'd0, 32'h203, 32'h0, 32'h400, 32'h1);
    check("jalr.ok.redirect", a_redirect, 1'b1);
    check("jalr.ok.target",   a_target,   32'h204);
    idle(3);

    // taken BNE, then a JAL presented during both flush cycles
    issue(2'd0, BR_BNE, 32'h1, 32'h2, 32'h300, 32'h10);
    check("bne.redirect", a_redirect, 1'b1);
    set_br(2'd1, 3'd0, '0, '0, 32'h500, 32'h8);
    br_valid = 1'b1;
    idle(2);
    br_valid = 1'b0;
    check("wrongpath.redirect", a_redirect,  1'b0);
    check("wrongpath.flush",    a_flush,     1'b0);
    check("wrongpath.br_cnt",   a_br_cnt,    16'd6);
    check("wrongpath.taken",    a_taken_cnt, 16'd5);
    check("wrongpath.target",   a_target,    32'h310);
    idle(2);

    // stall held 3 cycles inside FLUSH
    issue(2'd0, BR_BNE, 32'h7, 32'h8, 32'h600, 32'h20);
    idle(1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("stall.flush_held", a_flush, 1'b1);
    end
    stall = 1'b0;
    idle(1);
    check("stall.flush_end", a_flush, 1'b0);
    check("stall.busy_end",  a_busy,  1'b0);

    // stall together with br_valid: not accepted until re-presented
    set_br(2'd1, 3'd0, '0, '0, 32'h700, 32'h100);
    stall = 1'b1;
    br_valid = 1'b1;
    idle(1);
    check("stallvalid.redirect", a_redirect, 1'b0);
    check("stallvalid.br_cnt",   a_br_cnt,   16'd7);
    stall = 1'b0;
    idle(1);
    br_valid = 1'b0;
    check("represent.redirect", a_redirect, 1'b1);
    check("represent.target",   a_target,   32'h800);
    check("represent.br_cnt",   a_br_cnt,   16'd8);
    idle(3);

    // reset during REDIRECT
    issue(2'd0, BR_BEQ, 32'h9, 32'h9, 32'h900, 32'h4);
    check("rstmid.pre.redirect", a_redirect, 1'b1);
    reset = 1'b1;
    idle(1);
    check("rstmid.redirect", a_redirect,  1'b0);
    check("rstmid.flush",    a_flush,     1'b0);
    check("rstmid.busy",     a_busy,      1'b0);
    check("rstmid.target",   a_target,    32'h0);
    check("rstmid.br_cnt",   a_br_cnt,    16'd0);
    check("rstmid.taken",    a_taken_cnt, 16'd0);
    reset = 1'b0;
    idle(1);
    check("rstmid.no_reissue", a_redirect, 1'b0);

    // 20 taken JALs: 4-bit counters saturate at 15
    for (int i = 0; i < 20; i++) begin
      issue(2'd1, 3'd0, '0, '0, 32'(i * 256), 32'h8);
      idle(3);
    end
    check("sat.a.br_cnt", a_br_cnt,    16'd20);
    check("sat.a.taken",  a_taken_cnt, 16'd20);
    check("sat.b.br_cnt", b_br_cnt,    4'd15);
    check("sat.b.taken",  b_taken_cnt, 4'd15);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + 32'($urandom_range(0, 2)) - 32'd1;
        2:       b = $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      reset    = ($urandom_range(0, 199) == 0);
      stall    = ($urandom_range(0, 9) == 0);
      br_valid = $urandom_range(0, 1) == 1;
      set_br(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, b,
             $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom);
      idle(1);
    end
    reset = 1'b0; stall = 1'b0; br_valid = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
